memory_arbiter: RTL and testbench

Two-port arbiter and sequencer for the CPU's single word-addressed memory port. It shares the memory between the CPU microcode datapath (port 0) and an I/O processor / DMA requester (port 1). It also sequences every access through a fixed wait-state count, then returns read data with a one-cycle acknowledge. It sits between the CPU's `memory_address` / `memory_data_in` path and the memory array.

---
 rtl/memory_pkg.sv | 45 ++++
 rtl/memory_arbiter_grant_select.sv | 61 ++++++
 rtl/memory_arbiter.sv | 170 +++++++++++++++++
 tb/tb_memory_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package memory_pkg;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        MS_IDLE   = 2'd0,
        MS_ACCESS = 2'd1,
        MS_DONE   = 2'd2
    } mstate_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_IO  = 1'b1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } xact_t;

    // Pick the transaction fields of the winning requester.
    function automatic xact_t select_xact(
        input logic              winner,
        input logic              cpu_we,
        input logic [ADDR_W-1:0] cpu_addr,
        input logic [DATA_W-1:0] cpu_wdata,
        input logic              io_we,
        input logic [ADDR_W-1:0] io_addr,
        input logic [DATA_W-1:0] io_wdata
    );
        xact_t t;
        if (winner == PORT_IO) begin
            t.we    = io_we;
            t.addr  = io_addr;
            t.wdata = io_wdata;
        end else begin
            t.we    = cpu_we;
            t.addr  = cpu_addr;
            t.wdata = cpu_wdata;
        end
        return t;
    endfunction

endpackage

// File: rtl/memory_arbiter_grant_select.sv
// Winner selection between CPU and IOP requests.
// MEMORY_ARBITER_ROUND_ROBIN_EN swaps fixed IOP priority for a last-grant round robin.
module grant_select
    import memory_pkg::*;
(
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    input  logic clock,
    input  logic reset,
    input  logic grant_take,
`endif
    input  logic cpu_req,
    input  logic io_req,
    output logic any_req,
    output logic winner
);

    assign any_req = cpu_req | io_req;

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    logic last_grant_q;
    logic last_grant_d;

    // Contested requests go to the port that did not win last time.
    always_comb begin
        winner       = PORT_IO;
        last_grant_d = last_grant_q;
        if (cpu_req && io_req) begin
            winner = ~last_grant_q;
        end else if (io_req) begin
            winner = PORT_IO;
        end else begin
            winner = PORT_CPU;
        end
        if (grant_take) begin
            last_grant_d = winner;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Last-grant register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            last_grant_q <= PORT_IO;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    // Fixed priority: IOP over CPU.
    always_comb begin
        winner = PORT_CPU;
        if (io_req) begin
            winner = PORT_IO;
        end else begin
            winner = PORT_CPU;
        end
    end
`endif

endmodule

// File: rtl/memory_arbiter.sv
// Two-port arbiter/sequencer for the single memory port, with fixed wait states.
// Optional round-robin arbitration via MEMORY_ARBITER_ROUND_ROBIN_EN.
module memory_arbiter
    import memory_pkg::*;
#(
    parameter int WAIT_STATES = 2,
    parameter int CW          = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cpu_req,
    input  logic         cpu_we,
    input  logic [15:31] cpu_address,
    input  logic [0:31]  cpu_wdata,
    output logic         cpu_ack,
    input  logic         io_req,
    input  logic         io_we,
    input  logic [15:31] io_address,
    input  logic [0:31]  io_wdata,
    output logic         io_ack,
    output logic [0:31]  rdata,
    output logic [15:31] memory_address,
    output logic         memory_we,
    output logic [0:31]  memory_data_out,
    input  logic [0:31]  memory_data_in,
    output logic         busy
);

    mstate_e      state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic         grant_q, grant_d;
    xact_t        xact_q, xact_d;
    logic [0:31]  rdata_q, rdata_d;

    logic         cpu_ack_q, cpu_ack_d;
    logic         io_ack_q, io_ack_d;
    logic         busy_q, busy_d;
    logic         mem_we_q, mem_we_d;
    logic [15:31] mem_addr_q, mem_addr_d;
    logic [0:31]  mem_wdata_q, mem_wdata_d;

    logic         any_req;
    logic         winner;
    logic         grant_take;

    assign grant_take = (state_q == MS_IDLE) && any_req;

    grant_select u_grant_select (
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        .clock      (clock),
        .reset      (reset),
        .grant_take (grant_take),
`endif
        .cpu_req    (cpu_req),
        .io_req     (io_req),
        .any_req    (any_req),
        .winner     (winner)
    );

    // State, counter, grant and transaction latches.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= MS_IDLE;
            count_q <= {CW{1'b0}};
            grant_q <= PORT_CPU;
            xact_q  <= '0;
            rdata_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            grant_q <= grant_d;
            xact_q  <= xact_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state: grant in IDLE, count down in ACCESS, capture read data on exit.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        grant_d = grant_q;
        xact_d  = xact_q;
        rdata_d = rdata_q;
        case (state_q)
            MS_IDLE: begin
                if (any_req) begin
                    state_d = MS_ACCESS;
                    grant_d = winner;
                    count_d = CW'(WAIT_STATES);
                    xact_d  = select_xact(winner, cpu_we, cpu_address, cpu_wdata,
                                          io_we, io_address, io_wdata);
                end else begin
                    state_d = MS_IDLE;
                end
            end
            MS_ACCESS: begin
                if (count_q != {CW{1'b0}}) begin
                    count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    state_d = MS_DONE;
                    if (!xact_q.we) begin
                        rdata_d = memory_data_in;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end
            end
            MS_DONE: begin
                state_d = MS_IDLE;
            end
            default: begin
                state_d = MS_IDLE;
            end
        endcase
    end

    // Outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        busy_d      = (state_d != MS_IDLE);
        mem_we_d    = 1'b0;
        mem_addr_d  = 17'h0_0000;
        mem_wdata_d = 32'h0000_0000;
        cpu_ack_d   = 1'b0;
        io_ack_d    = 1'b0;
        if (state_d == MS_ACCESS) begin
            mem_we_d    = xact_d.we;
            mem_addr_d  = xact_d.addr;
            mem_wdata_d = xact_d.wdata;
        end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = 17'h0_0000;
            mem_wdata_d = 32'h0000_0000;
        end
        if (state_d == MS_DONE) begin
            cpu_ack_d = (grant_d == PORT_CPU);
            io_ack_d  = (grant_d == PORT_IO);
        end else begin
            cpu_ack_d = 1'b0;
            io_ack_d  = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            busy_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 17'h0_0000;
            mem_wdata_q <= 32'h0000_0000;
            cpu_ack_q   <= 1'b0;
            io_ack_q    <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            io_ack_q    <= io_ack_d;
        end
    end

    assign cpu_ack         = cpu_ack_q;
    assign io_ack          = io_ack_q;
    assign busy            = busy_q;
    assign rdata           = rdata_q;
    assign memory_we       = mem_we_q;
    assign memory_address  = mem_addr_q;
    assign memory_data_out = mem_wdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: WAIT_STATES=2 instance plus a WAIT_STATES=0 instance.
module tb_memory_arbiter;
    import memory_pkg::*;

    localparam int WS = 2;

    typedef struct packed {
        logic        port;
        logic [16:0] addr;
        logic [31:0] rdata;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic         cpu_req, cpu_we, io_req, io_we, cpu_ack, io_ack, memory_we, busy;
    logic [15:31] cpu_address, io_address, memory_address;
    logic [0:31]  cpu_wdata, io_wdata, rdata, memory_data_out, memory_data_in;

    logic         b_cpu_req, b_cpu_we, b_io_req, b_io_we, b_cpu_ack, b_io_ack, b_memory_we, b_busy;
    logic [15:31] b_cpu_address, b_io_address, b_memory_address;
    logic [0:31]  b_cpu_wdata, b_io_wdata, b_rdata, b_memory_data_out, b_memory_data_in;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t sb[$];
    exp_t sbb[$];

    function automatic logic [31:0] mem_model(input logic [16:0] a);
        if (a == 17'h0_0010) return 32'hDEAD_BEEF;
        return {15'h0000, a} ^ 32'hA5A5_0000;
    endfunction

    assign memory_data_in   = mem_model(memory_address);
    assign b_memory_data_in = mem_model(b_memory_address);

    memory_arbiter #(.WAIT_STATES(WS), .CW(4)) u_dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_address(cpu_address), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .io_req(io_req), .io_we(io_we), .io_address(io_address), .io_wdata(io_wdata), .io_ack(io_ack),
        .rdata(rdata), .memory_address(memory_address), .memory_we(memory_we),
        .memory_data_out(memory_data_out), .memory_data_in(memory_data_in), .busy(busy)
    );

    memory_arbiter #(.WAIT_STATES(0), .CW(4)) u_dut_ws0 (
        .clock(clock), .reset(reset),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_address(b_cpu_address), .cpu_wdata(b_cpu_wdata), .cpu_ack(b_cpu_ack),
        .io_req(b_io_req), .io_we(b_io_we), .io_address(b_io_address), .io_wdata(b_io_wdata), .io_ack(b_io_ack),
        .rdata(b_rdata), .memory_address(b_memory_address), .memory_we(b_memory_we),
        .memory_data_out(b_memory_data_out), .memory_data_in(b_memory_data_in), .busy(b_busy)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pop_a(output exp_t e);
        if (sb.size() != 0) e = sb.pop_front();
        else e = '0;
    endtask

    // Advance until an ack on the main instance; cycles = -1 if the bound expires.
    task automatic wait_ack(output int cycles, output int we_cycles, output logic [16:0] we_addr,
                            output logic [31:0] we_data, output logic both);
        cycles = -1; we_cycles = 0; we_addr = 17'h0_0000; we_data = 32'h0; both = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (memory_we) begin
                we_cycles++;
                we_addr = memory_address;
                we_data = memory_data_out;
            end
            if (cpu_ack && io_ack) both = 1'b1;
            if (cpu_ack || io_ack) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        {cpu_req, cpu_we, io_req, io_we} = 4'b0000;
        cpu_address = 17'h0; io_address = 17'h0; cpu_wdata = 32'h0; io_wdata = 32'h0;
        {b_cpu_req, b_cpu_we, b_io_req, b_io_we} = 4'b0000;
        b_cpu_address = 17'h0; b_io_address = 17'h0; b_cpu_wdata = 32'h0; b_io_wdata = 32'h0;
        tick(); tick();
        n_checks++;
        if ({cpu_ack, io_ack, busy, memory_we, memory_address, memory_data_out, rdata} !== 86'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ack=%b%b busy=%b we=%b addr=%h wd=%h rd=%h expected all 0",
                     cpu_ack, io_ack, busy, memory_we, memory_address, memory_data_out, rdata);
        end
        n_checks++;
        if ({b_cpu_ack, b_io_ack, b_busy, b_memory_we, b_memory_address, b_memory_data_out, b_rdata} !== 86'h0) begin
            n_fail++;
            $display("FAIL reset_outputs_ws0: got ack=%b%b busy=%b we=%b addr=%h wd=%h rd=%h expected all 0",
                     b_cpu_ack, b_io_ack, b_busy, b_memory_we, b_memory_address, b_memory_data_out, b_rdata);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_cpu_read();
        int cyc, wec; logic [16:0] wa; logic [31:0] wd; logic both; exp_t e;
        sb.push_back('{PORT_CPU, 17'h0_0010, 32'hDEAD_BEEF});
        cpu_we = 1'b0; cpu_address = 17'h0_0010; cpu_wdata = 32'hCAFE_F00D; cpu_req = 1'b1;
        tick();
        n_checks++;
        if ({busy, memory_we, memory_address} !== {1'b1, 1'b0, 17'h0_0010}) begin
            n_fail++;
            $display("FAIL cpu_read_access: got busy=%b we=%b addr=%h expected 1 0 00010", busy, memory_we, memory_address);
        end
        cpu_address = 17'h0_0ABC;  // transaction must already be latched
        wait_ack(cyc, wec, wa, wd, both);
        n_checks++;
        if (cyc !== WS + 1) begin
            n_fail++; $display("FAIL cpu_read_latency: got %0d expected %0d", cyc + 1, WS + 2);
        end
        n_checks++;
        if ({wec, cpu_ack, io_ack} !== {32'd0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL cpu_read_ack: got we_cycles=%0d acks=%b%b expected 0 10", wec, cpu_ack, io_ack);
        end
        pop_a(e);
        n_checks++;
        if (rdata !== e.rdata) begin
            n_fail++; $display("FAIL cpu_read_rdata: got %h expected %h", rdata, e.rdata);
        end
        cpu_req = 1'b0;
        tick();
        n_checks++;
        if ({cpu_ack, busy, rdata} !== {1'b0, 1'b0, 32'hDEAD_BEEF}) begin
            n_fail++; $display("FAIL cpu_read_after: got ack=%b busy=%b rd=%h expected 0 0 deadbeef", cpu_ack, busy, rdata);
        end
    endtask

    task automatic test_io_write();
        int cyc, wec; logic [16:0] wa; logic [31:0] wd; logic both; exp_t e;
        sb.push_back('{PORT_IO, 17'h1_FFFF, 32'hDEAD_BEEF});
        io_we = 1'b1; io_address = 17'h1_FFFF; io_wdata = 32'h1234_5678; io_req = 1'b1;
        wait_ack(cyc, wec, wa, wd, both);
        pop_a(e);
        n_checks++;
        if (cyc !== WS + 2) begin
            n_fail++; $display("FAIL io_write_latency: got %0d expected %0d", cyc, WS + 2);
        end
        n_checks++;
        if (wec !== WS + 1) begin
            n_fail++; $display("FAIL io_write_we_cycles: got %0d expected %0d", wec, WS + 1);
        end
        n_checks++;
        if ({wa, wd} !== {e.addr, 32'h1234_5678}) begin
            n_fail++; $display("FAIL io_write_bus: got addr=%h data=%h expected %h 12345678", wa, wd, e.addr);
        end
        n_checks++;
        if ({io_ack, cpu_ack, rdata} !== {1'b1, 1'b0, e.rdata}) begin
            n_fail++; $display("FAIL io_write_ack: got acks=%b%b rd=%h expected 10 %h", io_ack, cpu_ack, rdata, e.rdata);
        end
        io_req = 1'b0; io_we = 1'b0;
        tick();
        n_checks++;
        if ({io_ack, memory_we, memory_address, memory_data_out} !== 51'h0) begin
            n_fail++; $display("FAIL io_write_after: got ack=%b we=%b addr=%h wd=%h expected 0", io_ack, memory_we, memory_address, memory_data_out);
        end
    endtask

    task automatic test_both();
        int cyc, wec; logic [16:0] wa; logic [31:0] wd; logic both; exp_t e; logic got_port;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        sb.push_back('{PORT_CPU, 17'h0_0123, mem_model(17'h0_0123)});
        sb.push_back('{PORT_IO,  17'h0_0456, mem_model(17'h0_0456)});
`else
        sb.push_back('{PORT_IO,  17'h0_0456, mem_model(17'h0_0456)});
        sb.push_back('{PORT_CPU, 17'h0_0123, mem_model(17'h0_0123)});
`endif
        cpu_we = 1'b0; cpu_address = 17'h0_0123; io_we = 1'b0; io_address = 17'h0_0456;
        cpu_req = 1'b1; io_req = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_ack(cyc, wec, wa, wd, both);
            pop_a(e);
            got_port = io_ack ? PORT_IO : PORT_CPU;
            n_checks++;
            if (cyc !== ((k == 0) ? WS + 2 : WS + 3)) begin
                n_fail++; $display("FAIL both_latency_%0d: got %0d expected %0d", k, cyc, (k == 0) ? WS + 2 : WS + 3);
            end
            n_checks++;
            if ({both, got_port, rdata} !== {1'b0, e.port, e.rdata}) begin
                n_fail++; $display("FAIL both_grant_%0d: got dual=%b port=%b rd=%h expected 0 %b %h", k, both, got_port, rdata, e.port, e.rdata);
            end
            if (got_port == PORT_IO) io_req = 1'b0;
            else cpu_req = 1'b0;
        end
        cpu_req = 1'b0; io_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        exp_t e; logic exp_ack; int k;
        k = 1;
        b_cpu_we = 1'b0; b_cpu_address = 17'h0_0010;
        sbb.push_back('{PORT_CPU, 17'h0_0010, mem_model(17'h0_0010)});
        b_cpu_req = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            exp_ack = ((t % 3) == 2);
            n_checks++;
            if (b_cpu_ack !== exp_ack) begin
                n_fail++; $display("FAIL b2b_ack_t%0d: got %b expected %b", t, b_cpu_ack, exp_ack);
            end
            if (b_cpu_ack) begin
                if (sbb.size() != 0) e = sbb.pop_front();
                else e = '0;
                n_checks++;
                if (b_rdata !== e.rdata) begin
                    n_fail++; $display("FAIL b2b_rdata_t%0d: got %h expected %h", t, b_rdata, e.rdata);
                end
                if (k < 4) begin
                    b_cpu_address = 17'h0_0010 + 17'(k * 16);
                    sbb.push_back('{PORT_CPU, b_cpu_address, mem_model(17'h0_0010 + 17'(k * 16))});
                    k++;
                end
            end
        end
        b_cpu_req = 1'b0;
        tick(); tick();
    endtask

    task automatic test_stream();
        int cyc, wec; logic [16:0] wa; logic [31:0] wd; logic both; exp_t e; logic got_port;
        for (int k = 0; k < 4; k++) begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            if (k % 2 == 0) sb.push_back('{PORT_CPU, 17'h0_0200, mem_model(17'h0_0200)});
            else sb.push_back('{PORT_IO, 17'h0_0300, mem_model(17'h0_0300)});
`else
            sb.push_back('{PORT_IO, 17'h0_0300, mem_model(17'h0_0300)});
`endif
        end
        cpu_we = 1'b0; cpu_address = 17'h0_0200; io_we = 1'b0; io_address = 17'h0_0300;
        cpu_req = 1'b1; io_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_ack(cyc, wec, wa, wd, both);
            pop_a(e);
            got_port = io_ack ? PORT_IO : PORT_CPU;
            n_checks++;
            if ({cyc, both, got_port, rdata} !== {((k == 0) ? WS + 2 : WS + 3), 1'b0, e.port, e.rdata}) begin
                n_fail++; $display("FAIL stream_%0d: got cyc=%0d dual=%b port=%b rd=%h expected port %b rd %h",
                                   k, cyc, both, got_port, rdata, e.port, e.rdata);
            end
        end
        cpu_req = 1'b0; io_req = 1'b0;
        tick(); tick();
    endtask

    task automatic test_reset_abort();
        int cyc, wec; logic [16:0] wa; logic [31:0] wd; logic both; exp_t e; logic seen;
        seen = 1'b0;
        cpu_we = 1'b0; cpu_address = 17'h0_0077; cpu_req = 1'b1;
        tick(); seen = seen | cpu_ack | io_ack;
        tick(); seen = seen | cpu_ack | io_ack;
        reset = 1'b0;
        tick();
        n_checks++;
        if ({seen, cpu_ack, io_ack, busy, memory_we, memory_address, memory_data_out, rdata} !== 87'h0) begin
            n_fail++;
            $display("FAIL abort_outputs: got seen=%b ack=%b%b busy=%b we=%b addr=%h wd=%h rd=%h expected all 0",
                     seen, cpu_ack, io_ack, busy, memory_we, memory_address, memory_data_out, rdata);
        end
        reset = 1'b1;
        sb.push_back('{PORT_CPU, 17'h0_0077, mem_model(17'h0_0077)});
        wait_ack(cyc, wec, wa, wd, both);
        pop_a(e);
        n_checks++;
        if ({cyc, cpu_ack, io_ack, rdata} !== {WS + 2, 1'b1, 1'b0, e.rdata}) begin
            n_fail++; $display("FAIL abort_retry: got cyc=%0d ack=%b%b rd=%h expected %0d 10 %h", cyc, cpu_ack, io_ack, rdata, WS + 2, e.rdata);
        end
        cpu_req = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_cpu_read();
        test_io_write();
        test_both();
        test_back_to_back();
        test_stream();
        test_reset_abort();
        n_checks++;
        if (sb.size() + sbb.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d leftover expected 0", sb.size() + sbb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
